// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised memory game.
//   A host loads a sequence of one-hot button codes through the cfg_* port.
//   Each round optionally replays entries 0..rodada on the LEDs, then checks
//   the player's presses against the sequence, with a per-press timeout.
//
// Build option: define JOGO_MOSTRA_SEQ_EN to enable LED playback of the
//   sequence (MOSTRA_LED / MOSTRA_APAGA). Without it, rounds go straight to
//   ESPERA. db_estado codes do not change between builds.
//
// Parameters:
//   NB    - number of buttons/LEDs (width of one sequence entry)
//   AW    - sequence address width, DEPTH = 2**AW
//   T_OUT - cycles allowed in ESPERA before a timeout
//   T_LED - cycles each LED stays lit and each gap lasts during playback
//
// Ports:
//   clock, reset       - clock; synchronous active-high reset
//   jogar              - start/restart request (level)
//   nivel              - 0: last round DEPTH/2-1, 1: last round DEPTH-1
//   botoes             - player buttons, active-high
//   cfg_we/addr/data   - sequence write port (INICIAL and FIM_* only)
//   leds               - LED drive
//   ganhou/perdeu/timeout - held outcome flags, mutually exclusive
//   pronto             - game finished, any outcome
//   db_estado          - current state code
//   db_rodada/db_jogada - current round / press index
module jogo_memoria_param #(
  parameter int NB    = 4,
  parameter int AW    = 4,
  parameter int T_OUT = 5000,
  parameter int T_LED = 500
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic          nivel,
  input  logic [NB-1:0] botoes,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [NB-1:0] cfg_data,
  output logic [NB-1:0] leds,
  output logic          ganhou,
  output logic          perdeu,
  output logic          timeout,
  output logic          pronto,
  output logic [3:0]    db_estado,
  output logic [AW-1:0] db_rodada,
  output logic [AW-1:0] db_jogada
);

  localparam int DEPTH = 2**AW;
  localparam int T_MAX = (T_OUT > T_LED) ? T_OUT : T_LED;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [AW-1:0] L_BAIXO   = AW'(DEPTH/2 - 1);
  localparam logic [AW-1:0] L_ALTO    = AW'(DEPTH - 1);
  localparam logic [TW-1:0] T_OUT_FIM = TW'(T_OUT - 1);
`ifdef JOGO_MOSTRA_SEQ_EN
  localparam logic [TW-1:0] T_LED_FIM = TW'(T_LED - 1);
`endif

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    MOSTRA_LED   = 4'd2,
    MOSTRA_APAGA = 4'd3,
    ESPERA       = 4'd4,
    REGISTRA     = 4'd5,
    COMPARA      = 4'd6,
    PROX_JOGADA  = 4'd7,
    PROX_RODADA  = 4'd8,
    FIM_ACERTO   = 4'd9,
    FIM_ERRO     = 4'd10,
    FIM_TIMEOUT  = 4'd11
  } estado_t;

  estado_t       estado, prox;
  logic [NB-1:0] mem [DEPTH];
  logic [TW-1:0] timer;
  logic          timer_en;
  logic [AW-1:0] rodada, jogada;
  logic [NB-1:0] valor;
  logic          nivel_q;
  logic          any_q;
  logic          press;
  logic          certo;
  logic          cfg_ok;
  logic [AW-1:0] limite;
`ifdef JOGO_MOSTRA_SEQ_EN
  logic [AW-1:0] k;
`endif

  // A press is the rising edge of "any button down". any_q tracks the buttons
  // in every state, so a button already held when ESPERA is entered never
  // produces an edge there.
  assign press  = (|botoes) & ~any_q;
  assign limite = nivel_q ? L_ALTO : L_BAIXO;
  assign certo  = (valor != '0) && ((valor & (valor - 1'b1)) == '0) &&
                  (valor == mem[jogada]);
  assign cfg_ok = (estado == INICIAL) || (estado == FIM_ACERTO) ||
                  (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);

  // Sequence memory: not affected by reset.
  always_ff @(posedge clock) begin
    if (cfg_we && cfg_ok) mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= INICIAL;
      timer   <= '0;
      rodada  <= '0;
      jogada  <= '0;
      valor   <= '0;
      nivel_q <= 1'b0;
      any_q   <= 1'b0;
`ifdef JOGO_MOSTRA_SEQ_EN
      k       <= '0;
`endif
    end else begin
      estado <= prox;
      any_q  <= |botoes;
      // Timer restarts on every state change, so each timed state starts at 0.
      if (prox != estado)  timer <= '0;
      else if (timer_en)   timer <= timer + 1'b1;
      case (estado)
        PREPARA: begin
          rodada  <= '0;
          jogada  <= '0;
          nivel_q <= nivel;
`ifdef JOGO_MOSTRA_SEQ_EN
          k       <= '0;
`endif
        end
        ESPERA: begin
          if (press) valor <= botoes;
        end
        PROX_JOGADA: begin
          jogada <= jogada + 1'b1;
        end
        PROX_RODADA: begin
          rodada <= rodada + 1'b1;
          jogada <= '0;
`ifdef JOGO_MOSTRA_SEQ_EN
          k      <= '0;
`endif
        end
`ifdef JOGO_MOSTRA_SEQ_EN
        MOSTRA_APAGA: begin
          if (timer == T_LED_FIM && k != rodada) k <= k + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    prox     = estado;
    leds     = '0;
    ganhou   = 1'b0;
    perdeu   = 1'b0;
    timeout  = 1'b0;
    pronto   = 1'b0;
    timer_en = 1'b0;
    case (estado)
      INICIAL: begin
        if (jogar) prox = PREPARA;
      end
      PREPARA: begin
`ifdef JOGO_MOSTRA_SEQ_EN
        prox = MOSTRA_LED;
`else
        prox = ESPERA;
`endif
      end
`ifdef JOGO_MOSTRA_SEQ_EN
      MOSTRA_LED: begin
        leds     = mem[k];
        timer_en = 1'b1;
        if (timer == T_LED_FIM) prox = MOSTRA_APAGA;
      end
      MOSTRA_APAGA: begin
        timer_en = 1'b1;
        if (timer == T_LED_FIM) prox = (k == rodada) ? ESPERA : MOSTRA_LED;
      end
`endif
      ESPERA: begin
        leds     = botoes;
        timer_en = 1'b1;
        if (press)                   prox = REGISTRA;
        else if (timer == T_OUT_FIM) prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        prox = COMPARA;
      end
      COMPARA: begin
        if (!certo)                prox = FIM_ERRO;
        else if (jogada != rodada) prox = PROX_JOGADA;
        else if (rodada != limite) prox = PROX_RODADA;
        else                       prox = FIM_ACERTO;
      end
      PROX_JOGADA: begin
        prox = ESPERA;
      end
      PROX_RODADA: begin
`ifdef JOGO_MOSTRA_SEQ_EN
        prox = MOSTRA_LED;
`else
        prox = ESPERA;
`endif
      end
      FIM_ACERTO: begin
        pronto = 1'b1;
        ganhou = 1'b1;
        if (jogar) prox = PREPARA;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
        leds   = mem[jogada];
        if (jogar) prox = PREPARA;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
        if (jogar) prox = PREPARA;
      end
      default: prox = INICIAL;
    endcase
  end

  assign db_estado = estado;
  assign db_rodada = rodada;
  assign db_jogada = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset, jogar, nivel, cfg_we;
  logic [3:0] botoes, cfg_addr, cfg_data;
  logic [3:0] leds;
  logic       ganhou, perdeu, timeout, pronto;
  logic [3:0] db_estado, db_rodada, db_jogada;

`ifdef JOGO_MOSTRA_SEQ_EN
  localparam int MOSTRA = 1;
`else
  localparam int MOSTRA = 0;
`endif

  jogo_memoria_param #(.NB(4), .AW(4), .T_OUT(100), .T_LED(4)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel),
    .botoes(botoes), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado), .db_rodada(db_rodada),
    .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_ok  = 0;

  // Model of the sequence memory.
  logic [3:0] seq [16];

  typedef struct {
    int         nv;
    int         fr;      // failing round, -1 = play to the end
    int         fp;      // failing press within that round
    logic [3:0] bad;     // value pressed at the failure point, 0 = no press
    int         e_estado;
    int         e_g, e_p, e_t;
    logic [3:0] e_leds;
    int         e_rod, e_jog;
  } vec_t;

  vec_t tab [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", nome, act, exp_v);
  endtask

  task automatic wait_state(input int code, input int budget, output int n);
    n = 0;
    while (int'(db_estado) != code && n < budget) begin
      tick();
      n++;
    end
    if (int'(db_estado) != code) check("wait_state", int'(db_estado), code);
  endtask

  // Waits for ESPERA, counting distinct LED flashes on the way.
  task automatic wait_espera(output int flashes);
    int  n;
    bit  prev;
    n = 0; flashes = 0; prev = 1'b0;
    while (int'(db_estado) != 4 && n < 400) begin
      tick();
      n++;
      if (leds != 4'd0 && !prev) flashes++;
      prev = (leds != 4'd0);
    end
    if (int'(db_estado) != 4) check("wait_espera", int'(db_estado), 4);
  endtask

  task automatic wait_pronto();
    int n;
    n = 0;
    while (!pronto && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic write_mem(input int a, input logic [3:0] d, input bit honored);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (honored) seq[a] = d;
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    tick();
    botoes = 4'd0;
  endtask

  task automatic start(input int nv);
    nivel = 1'(nv);
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
  endtask

  task automatic play(input vec_t v);
    int lim, fl, n;
    bit fim;
    lim = (v.nv != 0) ? 15 : 7;
    fim = 1'b0;
    start(v.nv);
    for (int r = 0; r <= lim && !fim; r++) begin
      for (int p = 0; p <= r; p++) begin
        if (p == 0) begin
          wait_espera(fl);
          check("flashes", fl, (MOSTRA != 0) ? r + 1 : 0);
        end else begin
          wait_state(4, 50, n);
        end
        if (r == v.fr && p == v.fp) begin
          if (v.bad == 4'd0) begin
            wait_state(11, 200, n);
            check("timeout_cycles", n, 100);
          end else begin
            press(v.bad);
          end
          fim = 1'b1;
          break;
        end
        press(seq[p]);
      end
    end
    wait_pronto();
  endtask

  task automatic check_final(input vec_t v);
    check("estado",  int'(db_estado), v.e_estado);
    check("ganhou",  int'(ganhou),    v.e_g);
    check("perdeu",  int'(perdeu),    v.e_p);
    check("timeout", int'(timeout),   v.e_t);
    check("pronto",  int'(pronto),    1);
    check("leds",    int'(leds),      int'(v.e_leds));
    check("rodada",  int'(db_rodada), v.e_rod);
    check("jogada",  int'(db_jogada), v.e_jog);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_estado"},  int'(db_estado), 0);
    check({tag, "_leds"},    int'(leds),      0);
    check({tag, "_ganhou"},  int'(ganhou),    0);
    check({tag, "_perdeu"},  int'(perdeu),    0);
    check({tag, "_timeout"}, int'(timeout),   0);
    check({tag, "_pronto"},  int'(pronto),    0);
    check({tag, "_rodada"},  int'(db_rodada), 0);
    check({tag, "_jogada"},  int'(db_jogada), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] init_seq [16];
    int         fl, n, kind, lim;
    vec_t       rv;

    init_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
    //         nv  fr  fp  bad    est g  p  t  leds   rod jog
    tab[0] = '{0, -1, -1, 4'h0,  9, 1, 0, 0, 4'h0,  7,  7};
    tab[1] = '{0,  2,  2, 4'h8, 10, 0, 1, 0, 4'h4,  2,  2};
    tab[2] = '{0,  1,  0, 4'h0, 11, 0, 0, 1, 4'h0,  1,  0};
    tab[3] = '{0,  0,  0, 4'h3, 10, 0, 1, 0, 4'h1,  0,  0};
    tab[4] = '{1, -1, -1, 4'h0,  9, 1, 0, 0, 4'h0, 15, 15};
    tab[5] = '{1,  9,  4, 4'hF, 10, 0, 1, 0, 4'h4,  9,  4};

    reset = 1'b1; jogar = 1'b0; nivel = 1'b0; botoes = 4'd0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 4'd0;
    for (int i = 0; i < 16; i++) seq[i] = 4'd0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("inicial");

    for (int i = 0; i < 16; i++) write_mem(i, init_seq[i], 1'b1);

    for (int i = 0; i < 6; i++) begin
      play(tab[i]);
      check_final(tab[i]);
    end

    // A button held through the end of round 0 must not count in round 1.
    start(0);
    wait_espera(fl);
    botoes = seq[0];
    tick();
    wait_espera(fl);
    repeat (20) tick();
    check("held_estado", int'(db_estado), 4);
    check("held_rodada", int'(db_rodada), 1);
    check("held_jogada", int'(db_jogada), 0);
    botoes = 4'd0;
    tick();
    press(seq[0]);
    wait_state(4, 50, n);
    check("held_next_jogada", int'(db_jogada), 1);
    press(seq[1]);
    wait_espera(fl);
    check("held_next_rodada", int'(db_rodada), 2);
    for (int p = 0; p < 3; p++) begin
      wait_state(4, 50, n);
      press(seq[p]);
    end
    wait_espera(fl);
    check("pre_reset_rodada", int'(db_rodada), 3);
    press(seq[0]);

    // Reset mid-round 3, then restart: memory must survive.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midreset");
    start(0);
    wait_espera(fl);
    press(4'b0001);
    wait_espera(fl);
    check("restart_rodada", int'(db_rodada), 1);
    check("restart_perdeu", int'(perdeu), 0);

    // Sequence writes are ignored during play, honoured in FIM states.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start(0);
    wait_espera(fl);
    write_mem(0, 4'b1000, 1'b0);
    press(4'b0001);
    wait_espera(fl);
    check("cfg_ignored_rodada", int'(db_rodada), 1);
    press(4'b1000);
    wait_pronto();
    check("cfg_ignored_erro", int'(db_estado), 10);
    write_mem(0, 4'b1000, 1'b1);
    start(0);
    wait_espera(fl);
    press(4'b1000);
    wait_espera(fl);
    check("cfg_honored_rodada", int'(db_rodada), 1);
    check("cfg_honored_perdeu", int'(perdeu), 0);
    press(4'b1111);
    wait_pronto();
    check("cfg_end_erro", int'(db_estado), 10);

    // Random games against the rule model.
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 16; i++) write_mem(i, 4'(1 << $urandom_range(0, 3)), 1'b1);
      kind = $urandom_range(0, 2);
      rv.nv = $urandom_range(0, 1);
      lim = (rv.nv != 0) ? 15 : 7;
      rv.fr = $urandom_range(0, lim);
      rv.fp = $urandom_range(0, rv.fr);
      rv.bad = 4'd0;
      if (kind == 0) begin
        rv.fr = -1; rv.fp = -1;
        rv.e_estado = 9; rv.e_g = 1; rv.e_p = 0; rv.e_t = 0;
        rv.e_leds = 4'd0; rv.e_rod = lim; rv.e_jog = lim;
      end else if (kind == 1) begin
        do rv.bad = 4'($urandom_range(1, 15)); while (rv.bad == seq[rv.fp]);
        rv.e_estado = 10; rv.e_g = 0; rv.e_p = 1; rv.e_t = 0;
        rv.e_leds = seq[rv.fp]; rv.e_rod = rv.fr; rv.e_jog = rv.fp;
      end else begin
        rv.e_estado = 11; rv.e_g = 0; rv.e_p = 0; rv.e_t = 1;
        rv.e_leds = 4'd0; rv.e_rod = rv.fr; rv.e_jog = rv.fp;
      end
      play(rv);
      check_final(rv);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/jogo_memoria_param.md
Name: jogo_memoria_param

Overview:
- Parametrised successor of the memory-game top.
- Stores a loadable sequence of one-hot button codes and plays rounds of growing length.
- Each round: optionally replays the sequence on the LEDs, then checks the player's presses with a per-press timeout.
- Generalised in button count, sequence depth and timing. Adds host-side sequence loading and LED playback.

Parameters:
- NB, 4, number of buttons/LEDs (width of one sequence entry)
- AW, 4, address width; sequence depth DEPTH = 2**AW
- T_OUT, 5000, clock cycles allowed between presses before timeout
- T_LED, 500, cycles each LED is lit and each gap lasts during playback

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jogar  in  1  start/restart request, level-sensitive
- nivel  in  1  0: last round index DEPTH/2-1; 1: last round index DEPTH-1
- botoes  in  NB  player buttons, active-high
- cfg_we  in  1  sequence write enable
- cfg_addr  in  AW  sequence write address
- cfg_data  in  NB  sequence write data
- leds  out  NB  LED drive
- ganhou  out  1  game won, held
- perdeu  out  1  wrong press, held
- timeout  out  1  press timeout, held
- pronto  out  1  game finished (any outcome)
- db_estado  out  4  current FSM state code
- db_rodada  out  AW  current round index
- db_jogada  out  AW  current press index within round

Behaviour:
- Reset: clock and reset are one clock domain; reset is synchronous, active-high. Reset goes to INICIAL; all outputs 0; counters 0. Sequence memory is NOT cleared.
- Reset mid-game: abort to INICIAL on the next edge. Flags clear.
- States and codes: INICIAL=0, PREPARA=1, MOSTRA_LED=2, MOSTRA_APAGA=3, ESPERA=4, REGISTRA=5, COMPARA=6, PROX_JOGADA=7, PROX_RODADA=8, FIM_ACERTO=9, FIM_ERRO=10, FIM_TIMEOUT=11.
- INICIAL:
  - jogar=1 → PREPARA.
  - PREPARA: clears rodada, jogada, timer and flags → MOSTRA_LED.
- Playback (k = 0..rodada):
  - MOSTRA_LED: leds=mem[k] for T_LED cycles → MOSTRA_APAGA.
  - MOSTRA_APAGA: leds=0 for T_LED cycles.
  - Then k+1, or ESPERA once k==rodada.
  - Presses during playback are ignored.
- ESPERA:
  - leds=botoes.
  - A press is a 0→1 transition of |botoes, edge-detected internally (one registered stage). A button held from before ESPERA does not count.
  - Press → REGISTRA: latches botoes.
  - Timer counts in ESPERA; reaching T_OUT-1 with no press → FIM_TIMEOUT.
- REGISTRA: → COMPARA; timer cleared.
- COMPARA: correct = latched value is one-hot AND equals mem[jogada].
  - Incorrect → FIM_ERRO.
  - Correct, jogada<rodada → PROX_JOGADA: jogada+1, → ESPERA.
  - Correct, jogada==rodada, rodada<L → PROX_RODADA: rodada+1, jogada=0, → MOSTRA_LED.
  - Correct, jogada==rodada, rodada==L → FIM_ACERTO.
  - L is taken from nivel sampled in PREPARA; later changes to nivel are ignored.
- FIM_ACERTO / FIM_ERRO / FIM_TIMEOUT:
  - pronto=1, plus ganhou, perdeu or timeout respectively. Each flag is exclusive and held.
  - leds=mem[jogada] in FIM_ERRO, otherwise 0.
  - jogar=1 → PREPARA; flags drop on that edge.
- cfg_we honoured only in INICIAL and the FIM_* states; ignored in all other states. Write takes effect the next cycle.
- Counter widths:
  - Timer width = $clog2(max(T_OUT, T_LED)+1).
  - rodada and jogada never wrap, because L ≤ DEPTH-1.

Optional Feature:
- Macro JOGO_MOSTRA_SEQ_EN.
- Defined: playback states active as above.
- Undefined:
  - MOSTRA_LED/MOSTRA_APAGA are never entered. PREPARA and PROX_RODADA go directly to ESPERA.
  - leds=botoes in ESPERA only, 0 elsewhere except FIM_ERRO.
  - db_estado codes are unchanged.

Test Plan:
Bench overrides: NB=4, AW=4, T_OUT=100, T_LED=4. Memory is loaded via cfg with 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
- Win, nivel=0: pulse jogar, answer each round correctly → 8 rounds; ganhou=1, pronto=1, db_rodada=7, db_estado=9. With the macro on, round r shows r+1 LED flashes of 4 cycles each.
- Wrong press: round 2, third press 4'b1000 instead of 4'b0100 → perdeu=1, db_estado=10, leds=4'b0100.
- Timeout: enter ESPERA, no press → timeout=1 exactly 100 cycles after entry, db_estado=11; ganhou=perdeu=0.
- Non-one-hot press: press 4'b0011 when 4'b0001 is expected → perdeu=1. Held button across round boundary is not counted as a press.
- Reset mid-round 3 → all outputs 0, db_estado=0. Restart with jogar, first press 4'b0001 accepted: memory preserved.
- cfg_we=1, cfg_addr=0, cfg_data=4'b1000 during ESPERA is ignored (round 0 expects 4'b0001). The same write in FIM_ERRO, then jogar → round 0 expects 4'b1000.
